// File: rtl/dmem_arb_pkg.sv
// -----------------------------------------------------------------------------
// dmem_arb_pkg
// Shared definitions for the data-memory arbiter slice.
//   - DMEM_ARB_LEN_W : default width of the DMA burst-length field
//   - arb_state_t    : arbiter FSM state encoding (ST_IDLE / ST_BURST)
//   - next_word_addr : word-step address increment, wrapping modulo 2^32
// No ports (package).
// -----------------------------------------------------------------------------
package dmem_arb_pkg;

   // Default burst-length field width; a burst carries at most 2^LEN_W-1 words.
   localparam int DMEM_ARB_LEN_W = 5;

   // FSM state encoding. Kept as plain constants so older tools that choke on
   // enums in ports or packages still elaborate this slice.
   typedef logic [0:0] arb_state_t;
   localparam arb_state_t ST_IDLE  = 1'b0;
   localparam arb_state_t ST_BURST = 1'b1;

   // Byte address of the next 32-bit word. Plain 32-bit addition, so a burst
   // that starts near the top of the address space wraps to 0x00000000.
   function automatic logic [31:0] next_word_addr(input logic [31:0] a);
      return a + 32'd4;
   endfunction

endpackage

// File: rtl/dmem_arb_burst.sv
// -----------------------------------------------------------------------------
// dmem_arb_burst
// Address / word-count generator for one DMA burst.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   load        : capture base_a, len and dir_in (burst acceptance)
//   advance     : one beat performed; step address by 4, count down by 1
//   base_a      : burst base byte address
//   len         : burst word count (non-zero when load is used)
//   dir_in      : burst direction, 1 = write to memory
//   addr        : byte address of the current beat
//   dir         : latched burst direction
//   last        : the current beat is the final one (remaining count == 1)
// -----------------------------------------------------------------------------
module dmem_arb_burst
   import dmem_arb_pkg::*;
#(
   parameter int LEN_W = DMEM_ARB_LEN_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic             advance,
   input  logic [31:0]      base_a,
   input  logic [LEN_W-1:0] len,
   input  logic             dir_in,
   output logic [31:0]      addr,
   output logic             dir,
   output logic             last
);

   logic [LEN_W-1:0] cnt;

   // Burst registers. A load always wins over advance; the arbiter never asks
   // for both at once, but giving load priority keeps a fresh burst clean.
   // When neither is asserted (idle, or a CPU-preempted beat) everything
   // holds, which is what freezes the burst during a preemption.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr <= '0;
         cnt  <= '0;
         dir  <= 1'b0;
      end else if (load) begin
         addr <= base_a;
         cnt  <= len;
         dir  <= dir_in;
      end else if (advance) begin
         addr <= next_word_addr(addr);
         cnt  <= cnt - LEN_W'(1);
      end
   end

   // The final beat is the one taken while exactly one word remains.
   always_comb begin
      last = (cnt == LEN_W'(1));
   end

endmodule

// File: rtl/dmem_arb.sv
// -----------------------------------------------------------------------------
// dmem_arb
// Arbiter between the CPU pipeline MEM stage and a DMA burst engine for a
// single-ported data memory (combinational read, write on rising clk).
// Ports:
//   clk, rst_n                     : clock, asynchronous active-low reset
//   cpu_req, cpu_we, cpu_a, cpu_wd : CPU access request
//   cpu_gnt, cpu_rd                : CPU access performed / read data
//   dma_req, dma_we, dma_a, dma_len: DMA burst request (direction, base, words)
//   dma_wd                         : DMA beat write data
//   dma_gnt, dma_rd                : DMA beat performed / read data
//   dma_done                       : one-cycle pulse at burst completion
//   mem_we, mem_a, mem_wd, mem_rd  : shared data-memory port
// Configuration macro:
//   DMEM_ARB_PREEMPT_EN : when defined, a CPU request during a burst takes the
//                         memory for that cycle and the burst is frozen.
// -----------------------------------------------------------------------------
module dmem_arb
   import dmem_arb_pkg::*;
#(
   parameter int LEN_W = DMEM_ARB_LEN_W
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cpu_req,
   input  logic             cpu_we,
   input  logic [31:0]      cpu_a,
   input  logic [31:0]      cpu_wd,
   output logic             cpu_gnt,
   output logic [31:0]      cpu_rd,
   input  logic             dma_req,
   input  logic             dma_we,
   input  logic [31:0]      dma_a,
   input  logic [LEN_W-1:0] dma_len,
   input  logic [31:0]      dma_wd,
   output logic             dma_gnt,
   output logic [31:0]      dma_rd,
   output logic             dma_done,
   output logic             mem_we,
   output logic [31:0]      mem_a,
   output logic [31:0]      mem_wd,
   input  logic [31:0]      mem_rd
);

`ifdef DMEM_ARB_PREEMPT_EN
   localparam bit PREEMPT = 1'b1;
`else
   localparam bit PREEMPT = 1'b0;
`endif

   arb_state_t  state;
   arb_state_t  state_next;
   logic        burst_load;
   logic [31:0] burst_addr;
   logic        burst_dir;
   logic        burst_last;

   // Address and remaining-count generator. It advances exactly on beats the
   // DMA actually performs, so a preempted cycle leaves it untouched.
   dmem_arb_burst #(
      .LEN_W (LEN_W)
   ) u_burst (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (burst_load),
      .advance (dma_gnt),
      .base_a  (dma_a),
      .len     (dma_len),
      .dir_in  (dma_we),
      .addr    (burst_addr),
      .dir     (burst_dir),
      .last    (burst_last)
   );

   // State register. Reset drops straight back to IDLE, which abandons any
   // burst in flight without a completion pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Grant and memory-port muxing. The CPU owns the port in IDLE whenever it
   // asks; a DMA request is only accepted on a CPU-free cycle, and that
   // acceptance cycle does no memory access. During BURST each cycle is a beat
   // unless preemption is built in and the CPU is asking. Everything is gated
   // by rst_n so the grants and write enable read 0 the instant reset asserts,
   // not just after the next edge. mem_a/mem_wd default to the CPU side so the
   // mux only switches while a DMA beat is in progress.
   always_comb begin
      state_next = state;
      burst_load = 1'b0;
      cpu_gnt    = 1'b0;
      dma_gnt    = 1'b0;
      dma_done   = 1'b0;
      mem_we     = 1'b0;
      mem_a      = cpu_a;
      mem_wd     = cpu_wd;
      if (rst_n) begin
         if (state == ST_IDLE) begin
            if (cpu_req) begin
               cpu_gnt = 1'b1;
               mem_we  = cpu_we;
            end else if (dma_req) begin
               if (dma_len == '0) begin
                  dma_done = 1'b1;
               end else begin
                  burst_load = 1'b1;
                  state_next = ST_BURST;
               end
            end
         end else begin
            if (PREEMPT && cpu_req) begin
               cpu_gnt = 1'b1;
               mem_we  = cpu_we;
            end else begin
               dma_gnt  = 1'b1;
               mem_a    = burst_addr;
               mem_wd   = dma_wd;
               mem_we   = burst_dir;
               dma_done = burst_last;
               if (burst_last) begin
                  state_next = ST_IDLE;
               end
            end
         end
      end
   end

   // Read data is shared; each requester qualifies it with its own grant.
   always_comb begin
      cpu_rd = mem_rd;
      dma_rd = mem_rd;
   end

endmodule

// File: tb/tb_dmem_arb.sv
// -----------------------------------------------------------------------------
// tb_dmem_arb
// Self-checking bench for dmem_arb. A small word memory backs the DUT memory
// port; a reference model keeps the outstanding burst as a queue of beat
// addresses plus its own copy of memory and is compared against the DUT on
// every falling clock edge. Directed sequences pin the model with literal
// expectations, then a randomized phase exercises arbitrary traffic and resets.
// Honours DMEM_ARB_PREEMPT_EN the same way the design does.
// -----------------------------------------------------------------------------
module tb_dmem_arb;
   import dmem_arb_pkg::*;

   localparam int LEN_W = DMEM_ARB_LEN_W;
`ifdef DMEM_ARB_PREEMPT_EN
   localparam bit PREEMPT = 1'b1;
`else
   localparam bit PREEMPT = 1'b0;
`endif

   logic             clk;
   logic             rst_n;
   logic             cpu_req, cpu_we;
   logic [31:0]      cpu_a, cpu_wd, cpu_rd;
   logic             cpu_gnt;
   logic             dma_req, dma_we;
   logic [31:0]      dma_a, dma_wd, dma_rd;
   logic [LEN_W-1:0] dma_len;
   logic             dma_gnt, dma_done;
   logic             mem_we;
   logic [31:0]      mem_a, mem_wd, mem_rd;

   int tests_run;
   int tests_failed;

   // Memory seen by the DUT and the model's own idea of memory contents.
   logic [31:0] phys_mem [0:1023];
   logic [31:0] ref_mem  [0:1023];

   // Model state: remaining beat addresses of the burst in flight.
   logic [31:0] beat_q [$];
   logic        beat_dir;

   // Actions decided at the falling edge, applied at the next rising edge.
   bit          pend_pop, pend_load, pend_ref_wr, pend_phys_wr;
   logic [31:0] pend_load_a, pend_ref_a, pend_ref_wd, pend_phys_a, pend_phys_wd;
   int          pend_load_n;
   logic        pend_load_dir;

   dmem_arb #(
      .LEN_W (LEN_W)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .cpu_req  (cpu_req),
      .cpu_we   (cpu_we),
      .cpu_a    (cpu_a),
      .cpu_wd   (cpu_wd),
      .cpu_gnt  (cpu_gnt),
      .cpu_rd   (cpu_rd),
      .dma_req  (dma_req),
      .dma_we   (dma_we),
      .dma_a    (dma_a),
      .dma_len  (dma_len),
      .dma_wd   (dma_wd),
      .dma_gnt  (dma_gnt),
      .dma_rd   (dma_rd),
      .dma_done (dma_done),
      .mem_we   (mem_we),
      .mem_a    (mem_a),
      .mem_wd   (mem_wd),
      .mem_rd   (mem_rd)
   );

   // 10-unit clock, rising edges at 5, 15, 25, ...
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Combinational memory read, word-indexed by the low address bits.
   assign mem_rd = phys_mem[mem_a[11:2]];

   // One comparison: count it, and report it if it does not match.
   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      tests_run++;
      if (actual !== expected) begin
         tests_failed++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
      end
   endtask

   // Drive one cycle of inputs shortly after the rising edge.
   task automatic applyStimulus(input logic c_req, input logic c_we,
                                input logic [31:0] c_a, input logic [31:0] c_wd,
                                input logic d_req, input logic d_we,
                                input logic [31:0] d_a, input logic [LEN_W-1:0] d_len,
                                input logic [31:0] d_wd);
      @(posedge clk);
      #1;
      cpu_req = c_req;
      cpu_we  = c_we;
      cpu_a   = c_a;
      cpu_wd  = c_wd;
      dma_req = d_req;
      dma_we  = d_we;
      dma_a   = d_a;
      dma_len = d_len;
      dma_wd  = d_wd;
   endtask

   // Reference model and per-cycle comparison. Expected behaviour comes from
   // the arbitration rules: no burst outstanding -> CPU first, then DMA accept
   // or zero-length completion; burst outstanding -> next queued beat, unless
   // the CPU preempts. Outputs are sampled mid-cycle, away from the edge.
   always @(negedge clk) begin : compare_proc
      logic        e_cpu, e_dma, e_done, e_we;
      logic [31:0] e_a, e_wd;
      e_cpu = 1'b0; e_dma = 1'b0; e_done = 1'b0; e_we = 1'b0;
      e_a = '0; e_wd = '0;
      pend_pop = 1'b0;
      pend_load = 1'b0;
      if (rst_n) begin
         if (beat_q.size() == 0) begin
            if (cpu_req) begin
               e_cpu = 1'b1; e_we = cpu_we; e_a = cpu_a; e_wd = cpu_wd;
            end else if (dma_req) begin
               if (dma_len == '0) begin
                  e_done = 1'b1;
               end else begin
                  pend_load     = 1'b1;
                  pend_load_a   = dma_a;
                  pend_load_n   = int'(dma_len);
                  pend_load_dir = dma_we;
               end
            end
         end else if (PREEMPT && cpu_req) begin
            e_cpu = 1'b1; e_we = cpu_we; e_a = cpu_a; e_wd = cpu_wd;
         end else begin
            e_dma    = 1'b1;
            e_we     = beat_dir;
            e_a      = beat_q[0];
            e_wd     = dma_wd;
            e_done   = (beat_q.size() == 1);
            pend_pop = 1'b1;
         end
      end
      checkOutput("cyc_cpu_gnt", {31'd0, cpu_gnt}, {31'd0, e_cpu});
      checkOutput("cyc_dma_gnt", {31'd0, dma_gnt}, {31'd0, e_dma});
      checkOutput("cyc_dma_done", {31'd0, dma_done}, {31'd0, e_done});
      checkOutput("cyc_mem_we", {31'd0, mem_we}, {31'd0, e_we});
      if (e_cpu || e_dma) begin
         checkOutput("cyc_mem_a", mem_a, e_a);
         if (e_we) begin
            checkOutput("cyc_mem_wd", mem_wd, e_wd);
         end else if (e_cpu) begin
            checkOutput("cyc_cpu_rd", cpu_rd, ref_mem[e_a[11:2]]);
         end else begin
            checkOutput("cyc_dma_rd", dma_rd, ref_mem[e_a[11:2]]);
         end
      end
      pend_ref_wr  = e_we;
      pend_ref_a   = e_a;
      pend_ref_wd  = e_wd;
      pend_phys_wr = mem_we;
      pend_phys_a  = mem_a;
      pend_phys_wd = mem_wd;
   end

   // Clock-edge effects: memory writes land, the beat queue advances or fills.
   always @(posedge clk) begin
      if (pend_phys_wr) phys_mem[pend_phys_a[11:2]] = pend_phys_wd;
      if (pend_ref_wr)  ref_mem[pend_ref_a[11:2]]   = pend_ref_wd;
      if (pend_pop && beat_q.size() != 0) void'(beat_q.pop_front());
      if (pend_load) begin
         beat_dir = pend_load_dir;
         for (int i = 0; i < pend_load_n; i++) begin
            beat_q.push_back(pend_load_a + 32'(4 * i));
         end
      end
      pend_pop = 1'b0; pend_load = 1'b0; pend_ref_wr = 1'b0; pend_phys_wr = 1'b0;
   end

   // Reset abandons whatever burst the model thought was in flight.
   always @(negedge rst_n) begin
      beat_q.delete();
   end

   // Directed sequences followed by randomized traffic.
   initial begin
      tests_run    = 0;
      tests_failed = 0;
      beat_dir     = 1'b0;
      for (int i = 0; i < 1024; i++) begin
         phys_mem[i] = 32'(i) * 32'h0101_0101 ^ 32'h5A5A_0000;
         ref_mem[i]  = 32'(i) * 32'h0101_0101 ^ 32'h5A5A_0000;
      end

      // Reset holds every grant low even with both requesters asking.
      rst_n = 1'b0;
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_a = 32'h40; cpu_wd = 32'h1234;
      dma_req = 1'b1; dma_we = 1'b1; dma_a = 32'h80; dma_len = 3; dma_wd = '0;
      #3;
      checkOutput("reset_cpu_gnt", {31'd0, cpu_gnt}, 32'd0);
      checkOutput("reset_dma_gnt", {31'd0, dma_gnt}, 32'd0);
      checkOutput("reset_dma_done", {31'd0, dma_done}, 32'd0);
      checkOutput("reset_mem_we", {31'd0, mem_we}, 32'd0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
      rst_n = 1'b1;

      // CPU store then load at 0x10.
      applyStimulus(1, 1, 32'h10, 32'hDEADBEEF, 0, 0, 0, 0, 0);
      #2;
      checkOutput("store_cpu_gnt", {31'd0, cpu_gnt}, 32'd1);
      checkOutput("store_mem_we", {31'd0, mem_we}, 32'd1);
      checkOutput("store_mem_a", mem_a, 32'h10);
      applyStimulus(1, 0, 32'h10, 0, 0, 0, 0, 0, 0);
      #2;
      checkOutput("load_cpu_gnt", {31'd0, cpu_gnt}, 32'd1);
      checkOutput("load_cpu_rd", cpu_rd, 32'hDEADBEEF);

      // Simultaneous requests: CPU first, burst accepted on the first free cycle.
      applyStimulus(1, 0, 32'h20, 0, 1, 0, 32'h200, 4, 0);
      #2;
      checkOutput("prio_cpu_gnt", {31'd0, cpu_gnt}, 32'd1);
      checkOutput("prio_dma_gnt", {31'd0, dma_gnt}, 32'd0);
      applyStimulus(0, 0, 0, 0, 1, 0, 32'h200, 4, 0);
      #2;
      checkOutput("accept_dma_gnt", {31'd0, dma_gnt}, 32'd0);
      checkOutput("accept_mem_we", {31'd0, mem_we}, 32'd0);
      for (int i = 0; i < 4; i++) begin
         applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
         #2;
         checkOutput("prio_beat_gnt", {31'd0, dma_gnt}, 32'd1);
         checkOutput("prio_beat_a", mem_a, 32'h200 + 32'(4 * i));
      end
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
      #2;
      checkOutput("prio_after_gnt", {31'd0, dma_gnt}, 32'd0);

      // DMA write burst at 0x100, four words.
      applyStimulus(0, 0, 0, 0, 1, 1, 32'h100, 4, 0);
      for (int i = 0; i < 4; i++) begin
         applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 32'hA000_0000 + 32'(i));
         #2;
         checkOutput("wr_beat_gnt", {31'd0, dma_gnt}, 32'd1);
         checkOutput("wr_beat_a", mem_a, 32'h100 + 32'(4 * i));
         checkOutput("wr_beat_we", {31'd0, mem_we}, 32'd1);
         checkOutput("wr_beat_done", {31'd0, dma_done}, (i == 3) ? 32'd1 : 32'd0);
      end
      applyStimulus(1, 0, 32'h108, 0, 0, 0, 0, 0, 0);
      #2;
      checkOutput("wr_readback", cpu_rd, 32'hA000_0002);

      // Address wrap at the top of the address space.
      applyStimulus(0, 0, 0, 0, 1, 0, 32'hFFFF_FFFC, 2, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
      #2;
      checkOutput("wrap_beat0_a", mem_a, 32'hFFFF_FFFC);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
      #2;
      checkOutput("wrap_beat1_a", mem_a, 32'h0000_0000);
      checkOutput("wrap_done", {31'd0, dma_done}, 32'd1);

      // Zero-length burst: completion only.
      applyStimulus(0, 0, 0, 0, 1, 1, 32'h180, 0, 0);
      #2;
      checkOutput("zero_done", {31'd0, dma_done}, 32'd1);
      checkOutput("zero_gnt", {31'd0, dma_gnt}, 32'd0);
      checkOutput("zero_we", {31'd0, mem_we}, 32'd0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
      #2;
      checkOutput("zero_done_clear", {31'd0, dma_done}, 32'd0);

      // CPU request in the middle of a write burst at 0x300.
      applyStimulus(0, 0, 0, 0, 1, 1, 32'h300, 4, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 32'hB000_0000);
      #2;
      checkOutput("mid_beat0_a", mem_a, 32'h300);
`ifdef DMEM_ARB_PREEMPT_EN
      applyStimulus(1, 0, 32'h300, 0, 0, 0, 0, 0, 32'hB000_0001);
      #2;
      checkOutput("preempt_cpu_gnt", {31'd0, cpu_gnt}, 32'd1);
      checkOutput("preempt_dma_gnt", {31'd0, dma_gnt}, 32'd0);
      checkOutput("preempt_cpu_rd", cpu_rd, 32'hB000_0000);
      for (int i = 1; i < 4; i++) begin
         applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 32'hB000_0000 + 32'(i));
         #2;
         checkOutput("resume_gnt", {31'd0, dma_gnt}, 32'd1);
         checkOutput("resume_a", mem_a, 32'h300 + 32'(4 * i));
      end
`else
      for (int i = 1; i < 4; i++) begin
         applyStimulus(1, 0, 32'h300, 0, 0, 0, 0, 0, 32'hB000_0000 + 32'(i));
         #2;
         checkOutput("wait_cpu_gnt", {31'd0, cpu_gnt}, 32'd0);
         checkOutput("wait_beat_a", mem_a, 32'h300 + 32'(4 * i));
         checkOutput("wait_done", {31'd0, dma_done}, (i == 3) ? 32'd1 : 32'd0);
      end
      applyStimulus(1, 0, 32'h300, 0, 0, 0, 0, 0, 0);
      #2;
      checkOutput("after_done_cpu_gnt", {31'd0, cpu_gnt}, 32'd1);
      checkOutput("after_done_cpu_rd", cpu_rd, 32'hB000_0000);
`endif

      // Reset in the middle of a read burst at 0x500.
      applyStimulus(0, 0, 0, 0, 1, 0, 32'h500, 4, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
      #2;
      checkOutput("rst_pre_beat_a", mem_a, 32'h504);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
      rst_n = 1'b0;
      #2;
      checkOutput("rst_mid_done", {31'd0, dma_done}, 32'd0);
      checkOutput("rst_mid_gnt", {31'd0, dma_gnt}, 32'd0);
      applyStimulus(1, 0, 32'h10, 0, 0, 0, 0, 0, 0);
      rst_n = 1'b1;
      #2;
      checkOutput("rst_idle_cpu_gnt", {31'd0, cpu_gnt}, 32'd1);
      checkOutput("rst_idle_dma_gnt", {31'd0, dma_gnt}, 32'd0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
      #2;
      checkOutput("rst_idle_no_beat", {31'd0, dma_gnt}, 32'd0);

      // Randomized traffic, including the occasional reset and wrapping burst.
      for (int n = 0; n < 3000; n++) begin
         logic [31:0] r_ca, r_da;
         r_ca = {20'd0, 10'($urandom), 2'b00};
         r_da = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFF4 : {20'd0, 10'($urandom), 2'b00};
         applyStimulus($urandom_range(0, 99) < 30, 1'($urandom), r_ca, $urandom,
                       $urandom_range(0, 99) < 25, 1'($urandom), r_da,
                       LEN_W'($urandom_range(0, 6)), $urandom);
         rst_n = ($urandom_range(0, 199) != 0);
      end
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/dmem_arb.md
DMEM_ARB -- requirements
Module: dmem_arb

Interface
REQ-001 SHALL have parameter LEN_W, default 5: width of the DMA burst-length field in words (maximum 2^LEN_W-1).
REQ-002 SHALL have port clk, input, 1: single rising-edge clock.
REQ-003 SHALL have port rst_n, input, 1: asynchronous active-low reset.
REQ-004 SHALL have ports cpu_req, input, 1, and cpu_we, input, 1: pipeline MEM-stage access request and write enable.
REQ-005 SHALL have ports cpu_a, input, 32, and cpu_wd, input, 32: CPU byte address and write data.
REQ-006 SHALL have ports cpu_gnt, output, 1, and cpu_rd, output, 32: access performed this cycle, and read data (valid when cpu_gnt=1 and cpu_we=0).
REQ-007 SHALL have ports dma_req, input, 1, dma_we, input, 1, dma_a, input, 32, and dma_len, input, LEN_W: burst request, burst direction, base address and word count.
REQ-008 SHALL have ports dma_wd, input, 32, dma_gnt, output, 1, and dma_rd, output, 32: beat write data, beat-performed strobe, and beat read data.
REQ-009 SHALL have port dma_done, output, 1: one-cycle pulse at burst completion.
REQ-010 SHALL have ports mem_we, output, 1, mem_a, output, 32, mem_wd, output, 32, and mem_rd, input, 32: the shared data-memory port (combinational read, write on clk rising edge).

Function
REQ-011 SHALL implement FSM states IDLE and BURST; state, burst address register and remaining-count register SHALL be the only state.
REQ-012 In IDLE with cpu_req=1, SHALL assert cpu_gnt in the same cycle, drive mem_a=cpu_a, mem_wd=cpu_wd and mem_we=cpu_we, and remain in IDLE (CPU has priority over a simultaneous dma_req).
REQ-013 In IDLE with cpu_req=0, dma_req=1 and dma_len!=0, SHALL latch dma_a, dma_we and dma_len, and enter BURST next cycle with no memory access this cycle.
REQ-014 In IDLE with cpu_req=0, dma_req=1 and dma_len=0, SHALL pulse dma_done for one cycle, perform no access, and stay in IDLE.
REQ-015 In each BURST beat, SHALL assert dma_gnt, drive mem_a = address register, mem_wd=dma_wd and mem_we = latched direction, then advance the address register by 4 (mod 2^32) and decrement the count.
REQ-016 On the beat with count=1, SHALL pulse dma_done in that same cycle and return to IDLE; a burst of N words therefore occupies N+1 cycles from IDLE acceptance.
REQ-017 SHALL ignore dma_req, dma_a and dma_len while in BURST.
REQ-018 SHALL drive cpu_rd = dma_rd = mem_rd combinationally; consumers qualify with their grant.
REQ-019 SHALL hold mem_we=0 whenever no grant is asserted; cpu_gnt and dma_gnt SHALL never be asserted together.

Reset
REQ-020 On rst_n=0, SHALL immediately enter IDLE, clear the count and address registers, and force cpu_gnt, dma_gnt, dma_done and mem_we to 0.
REQ-021 A reset during BURST SHALL abandon the burst without asserting dma_done.

Configuration
REQ-022 With DMEM_ARB_PREEMPT_EN defined, cpu_req=1 in BURST SHALL grant the CPU that cycle (REQ-012 muxing), deassert dma_gnt, and freeze the address and count registers; the burst resumes on the next cycle without cpu_req.
REQ-023 Without DMEM_ARB_PREEMPT_EN, cpu_gnt SHALL be 0 throughout BURST, and the CPU waits until the cycle after dma_done.

Structure
REQ-024 SHALL place the state enum and the default LEN_W in package dmem_arb_pkg.
REQ-025 SHALL implement the address/count generator as the single sub-module dmem_arb_burst (load, advance, last outputs).

Verification
REQ-026 Bench SHALL check: CPU store a=0x10, wd=0xDEADBEEF with no DMA request -> cpu_gnt=1 and mem_we=1 in the same cycle; a subsequent load at 0x10 returns cpu_rd=0xDEADBEEF.
REQ-027 Bench SHALL check: cpu_req and dma_req (len=4) both asserted in IDLE -> CPU is granted; the burst is accepted in the first cycle with cpu_req=0.
REQ-028 Bench SHALL check: DMA write burst a=0x100, len=4 -> mem_a takes 0x100, 0x104, 0x108 and 0x10C on consecutive dma_gnt cycles, and dma_done coincides with the 0x10C beat.
REQ-029 Bench SHALL check: burst from a=0xFFFFFFFC with len=2 -> second beat at mem_a=0x00000000.
REQ-030 Bench SHALL check: dma_len=0 -> single dma_done pulse, with no dma_gnt and no mem_we.
REQ-031 Bench SHALL check: with the macro defined, cpu_req raised mid-burst -> CPU is granted for one cycle and the burst resumes at the next address; without the macro, cpu_gnt=0 until after dma_done; rst_n pulsed mid-burst -> IDLE with no dma_done.
